// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that feeds several word requesters into one FIFO write port.
// A granted requester streams a burst of up to MAX_BURST words (one word when the FIFO is half full).
module fifo_wr_arbiter #(
  parameter int unsigned DATA_SIZE = 9,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                           wclk,
  input  logic                           wrst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           wFull,
  input  logic                           wHalf_full,
  output logic                           winc,
  output logic [DATA_SIZE-1:0]           wData,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic [15:0]                    word_cnt
);

  localparam int unsigned IdW   = $clog2(NUM_REQ);
  localparam int unsigned BeatW = $clog2(MAX_BURST + 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [IdW-1:0]   last_q, last_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [IdW-1:0]   pick;
  logic             found;
  logic [BeatW-1:0] limit;
  logic [BeatW-1:0] beat_nx;
  logic             xfer;

  // Search upward from the requester after the last grant, wrapping at NUM_REQ.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      int unsigned idx;
      idx = (32'(last_q) + off) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        pick  = IdW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    busy      = (state_q == StBurst);
    req_ready = '0;
    if (busy && !wFull) begin
      req_ready[grant_q] = 1'b1;
    end
    xfer     = req_valid[grant_q] & req_ready[grant_q];
    winc     = xfer;
    wData    = req_data[int'(grant_q) * DATA_SIZE +: DATA_SIZE];
    grant_id = grant_q;
    word_cnt = cnt_q;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    limit   = wHalf_full ? BeatW'(1) : BeatW'(MAX_BURST);
    beat_nx = beat_q + BeatW'(1);
    unique case (state_q)
      StIdle: begin
        if (found && !wFull) begin
          grant_d = pick;
          last_d  = pick;
          beat_d  = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        // A dropped valid ends the burst even while the FIFO is full.
        if (!req_valid[grant_q]) begin
          state_d = StIdle;
        end else if (xfer) begin
          beat_d = beat_nx;
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          if (beat_nx >= limit) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdW'(NUM_REQ - 1);
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations plus a randomized
// run checked every cycle against a transaction-level model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int DW = 9;
  localparam int NR = 4;
  localparam int MB = 8;

  logic              wclk = 1'b0;
  logic              wrst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic              wFull = 1'b0;
  logic              wHalf_full = 1'b0;
  logic [NR-1:0]     req_ready;
  logic              winc;
  logic [DW-1:0]     wData;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       word_cnt;

  fifo_wr_arbiter #(.DATA_SIZE(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wFull(wFull), .wHalf_full(wHalf_full), .winc(winc),
    .wData(wData), .grant_id(grant_id), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 wclk = ~wclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge wclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: cur is the requester owning the write port (-1 when none), show is what grant_id reports.
  typedef struct {int cur; int last; int show; int beats; int words;} model_t;
  model_t m = '{cur: -1, last: NR - 1, show: 0, beats: 0, words: 0};

  function automatic model_t model_reset();
    model_t r = '{cur: -1, last: NR - 1, show: 0, beats: 0, words: 0};
    return r;
  endfunction

  function automatic model_t model_step(model_t s, logic [NR-1:0] v, logic full, logic half);
    model_t n = s;
    if (s.cur < 0) begin
      if (v != '0 && !full) begin
        for (int k = 1; k <= NR; k++) begin
          int c = (s.last + k) % NR;
          if (v[c]) begin
            n.cur = c; n.last = c; n.show = c; n.beats = 0;
            break;
          end
        end
      end
    end else if (!v[s.cur]) begin
      n.cur = -1;
    end else if (!full) begin
      n.words = (s.words == 65535) ? 65535 : s.words + 1;
      n.beats = s.beats + 1;
      if (n.beats >= (half ? 1 : MB)) n.cur = -1;
    end
    return n;
  endfunction

  always @(posedge wclk or posedge wrst) begin
    if (wrst) m <= model_reset();
    else      m <= model_step(m, req_valid, wFull, wHalf_full);
  end

  logic [NR-1:0] e_ready;
  logic          e_busy;
  logic          e_winc;
  always @(negedge wclk) begin
    e_busy  = (m.cur >= 0);
    e_ready = '0;
    if (e_busy && !wFull) e_ready[m.cur] = 1'b1;
    e_winc  = e_busy && !wFull && req_valid[m.cur];
    chk("req_ready", req_ready, e_ready);
    chk("winc", winc, e_winc);
    chk("busy", busy, e_busy);
    chk("grant_id", grant_id, m.show);
    chk("wData", wData, req_data[m.show*DW +: DW]);
    chk("word_cnt", word_cnt, m.words);
  end

  typedef struct {int g; int d; int c;} ev_t;
  ev_t log_q[$];
  always @(negedge wclk) begin
    if (winc === 1'b1) log_q.push_back('{g: int'(grant_id), d: int'(wData), c: cyc});
  end

  task automatic step();
    @(posedge wclk);
    #2;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    for (int i = 0; i < budget && log_q.size() < n; i++) step();
    chk(name, log_q.size() >= n, 1);
  endtask

  task automatic pulse_reset();
    wrst = 1'b1;
    step();
    wrst = 1'b0;
  endtask

  int exp33[5] = '{0, 1, 2, 3, 0};
  int c0;
  int held;

  initial begin
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(9'h100 | (i * 17));
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_winc", winc, 0);
    wrst = 1'b0;
    step();

    // All four requesters continuously valid: five full bursts in rotation.
    log_q.delete();
    c0 = cyc;
    req_valid = '1;
    for (int i = 0; i < 100 && word_cnt < 16'd40; i++) step();
    req_valid = '0;
    step();
    step();
    chk("r33_count", log_q.size(), 40);
    if (log_q.size() == 40) begin
      chk("r33_latency", log_q[0].c, c0 + 1);
      for (int i = 0; i < 40; i++) begin
        chk("r33_grant", log_q[i].g, exp33[i / 8]);
        if (i > 0) chk("r33_spacing", log_q[i].c - log_q[i-1].c, (i % 8 == 0) ? 2 : 1);
      end
    end

    // Only requester 2, three words then valid drops.
    log_q.delete();
    req_valid = 4'b0100;
    wait_log(3, 20, "r34_wait");
    req_valid = '0;
    step();
    step();
    chk("r34_count", log_q.size(), 3);
    for (int i = 0; i < log_q.size(); i++) begin
      chk("r34_grant", log_q[i].g, 2);
      chk("r34_data", log_q[i].d, 9'h122);
      if (i > 0) chk("r34_spacing", log_q[i].c - log_q[i-1].c, 1);
    end
    chk("r34_gid_after", grant_id, 2);
    chk("r34_idle_after", busy, 0);

    // Full FIFO stalls requester 1 after three beats; the burst still completes eight words.
    log_q.delete();
    req_valid = 4'b0010;
    wait_log(3, 20, "r35_wait");
    wFull = 1'b1;
    held = log_q.size();
    repeat (5) step();
    chk("r35_stall_count", log_q.size(), held);
    chk("r35_stall_busy", busy, 1);
    chk("r35_stall_gid", grant_id, 1);
    wFull = 1'b0;
    for (int i = 0; i < 30 && busy; i++) step();
    req_valid = '0;
    step();
    chk("r35_total", log_q.size(), 8);
    chk("r35_word_cnt", word_cnt, 51);

    // Half-full FIFO limits bursts to one word, alternating 0 and 1.
    log_q.delete();
    wHalf_full = 1'b1;
    req_valid = 4'b0011;
    wait_log(4, 40, "r36_wait");
    req_valid = '0;
    wHalf_full = 1'b0;
    step();
    step();
    chk("r36_count", log_q.size(), 4);
    for (int i = 0; i < log_q.size(); i++) begin
      chk("r36_grant", log_q[i].g, i % 2);
      if (i > 0) chk("r36_spacing", log_q[i].c - log_q[i-1].c, 2);
    end

    // Reset during beat 4 of requester 1.
    pulse_reset();
    log_q.delete();
    req_valid = '1;
    wait_log(11, 40, "r37_wait");
    if (log_q.size() >= 11) chk("r37_owner", log_q[10].g, 1);
    wrst = 1'b1;
    #1;
    chk("r37_winc", winc, 0);
    chk("r37_ready", req_ready, 0);
    chk("r37_busy", busy, 0);
    chk("r37_cnt", word_cnt, 0);
    step();
    step();
    wrst = 1'b0;
    log_q.delete();
    wait_log(1, 10, "r37_restart");
    if (log_q.size() >= 1) chk("r37_first_grant", log_q[0].g, 0);
    chk("r37_cnt_restart", word_cnt, 1);
    req_valid = '0;
    step();

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      req_valid  = NR'($urandom);
      wFull      = ($urandom_range(0, 4) == 0);
      wHalf_full = ($urandom_range(0, 3) == 0);
      for (int r = 0; r < NR; r++) req_data[r*DW +: DW] = DW'($urandom);
      wrst       = ($urandom_range(0, 299) == 0);
      step();
    end
    wrst = 1'b0;
    wFull = 1'b0;
    wHalf_full = 1'b0;

    // Saturation of the word counter.
    pulse_reset();
    log_q.delete();
    req_valid = '1;
    for (int i = 0; i < 80000 && log_q.size() < 65540; i++) step();
    chk("r38_transfers", log_q.size() >= 65540, 1);
    chk("r38_saturate", word_cnt, 16'hFFFF);
    req_valid = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 9: width of each requester data word and of the FIFO write data.
REQ-002 Parameter NUM_REQ, default 4: number of write requesters; legal values 2..8.
REQ-003 Parameter MAX_BURST, default 8: maximum words per grant; legal values 1..16.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high (ports wclk, wrst).
REQ-005 wclk  input  1  write-domain clock; all state changes on its rising edge.
REQ-006 wrst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester word-available flag.
REQ-008 req_data  input  NUM_REQ*DATA_SIZE  requester i word in bits [i*DATA_SIZE +: DATA_SIZE].
REQ-009 req_ready  output  NUM_REQ  per-requester word-accepted strobe.
REQ-010 wFull  input  1  FIFO write-side full flag.
REQ-011 wHalf_full  input  1  FIFO write-side half-full flag.
REQ-012 winc  output  1  FIFO write enable.
REQ-013 wData  output  DATA_SIZE  FIFO write data.
REQ-014 grant_id  output  clog2(NUM_REQ)  index of the currently or last granted requester.
REQ-015 busy  output  1  high while in BURST.
REQ-016 word_cnt  output  16  total words written; saturates at 16'hFFFF.

Function
REQ-017 The FSM SHALL have two states: IDLE and BURST.
REQ-018 In IDLE with any req_valid high and wFull low, the block SHALL select a requester round-robin, searching upward from last_grant+1 modulo NUM_REQ, register it into grant_id and last_grant, clear beat_cnt, and enter BURST on the next edge.
REQ-019 In IDLE with wFull high, the block SHALL stay in IDLE and make no selection.
REQ-020 req_ready[i] SHALL be combinational: high only when state=BURST, i=grant_id and wFull=0.
REQ-021 winc SHALL equal req_valid[grant_id] & req_ready[grant_id]; wData SHALL equal the grant_id slice of req_data, combinationally.
REQ-022 A transfer is a cycle with winc=1; each transfer SHALL increment beat_cnt and word_cnt (saturating).
REQ-023 Burst limit SHALL be 1 when wHalf_full=1 in the transfer cycle, else MAX_BURST.
REQ-024 BURST SHALL exit to IDLE after a transfer in which beat_cnt+1 reaches the burst limit.
REQ-025 BURST SHALL exit to IDLE in any cycle where req_valid[grant_id]=0, with no transfer in that cycle.
REQ-026 In BURST with wFull=1, the block SHALL hold state, grant_id and beat_cnt with no transfer, for any number of cycles.
REQ-027 Latency: a request seen in IDLE SHALL produce its first winc no earlier than the following cycle; IDLE costs exactly one cycle between bursts.
REQ-028 Requests from non-granted requesters SHALL be ignored until the block returns to IDLE.
REQ-029 A requester SHALL NOT receive two consecutive grants while any other requester has req_valid high in the IDLE decision cycle.

Reset
REQ-030 On wrst=1, the block SHALL asynchronously go to IDLE with grant_id=0, last_grant=NUM_REQ-1, beat_cnt=0, word_cnt=0 and busy=0, forcing req_ready=0 and winc=0.
REQ-031 If reset occurs mid-burst, the in-flight burst SHALL be abandoned and no winc SHALL be asserted while wrst=1.
REQ-032 After reset release, the first grant SHALL go to the lowest-index valid requester.

Verification
REQ-033 All four valid continuously, wFull=0, wHalf_full=0 -> grants in order 0,1,2,3,0; 8 winc per burst; 1 idle cycle between bursts.
REQ-034 Only requester 2 valid, for 3 words -> 3 consecutive winc with wData = req 2 words, then IDLE; grant_id=2.
REQ-035 wFull raised for 5 cycles after beat 3 of a burst -> no winc and beat_cnt held at 3 during those cycles; burst resumes and completes 8 words.
REQ-036 wHalf_full=1 with requesters 0 and 1 valid -> single-word bursts alternating 0,1,0,1.
REQ-037 wrst pulsed during beat 4 of requester 1 -> winc=0 and req_ready=0 immediately; after release with all valid, the first grant is 0 and word_cnt restarts from 0.
REQ-038 70000 transfers -> word_cnt saturates at 16'hFFFF.
